// File: rtl/axi2apb_wr_sequencer.sv
// Write-path controller of the AXI2APB bridge.
// Commands the AXI write reader, steps each buffered beat out as one APB
// write with a FIXED/INCR/WRAP address, pops the beat FIFO, and folds the
// per-beat APB results into a single burst response for the B channel.
module axi2apb_wr_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic [1:0]            rd_cmd,
    input  logic [1:0]            rd_info,
    input  logic [ADDR_WIDTH-1:0] ai_addr,
    input  logic [3:0]            ai_len,
    input  logic [2:0]            ai_size,
    input  logic [1:0]            ai_burst,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic                  apb_cmd_valid,
    input  logic                  apb_cmd_ready,
    output logic [ADDR_WIDTH-1:0] apb_cmd_addr,
    input  logic                  apb_done,
    input  logic                  apb_slverr,
    output logic [1:0]            resp,
    output logic                  busy
);

    // Largest legal AWSIZE for this data bus width
    localparam int          MAX_SIZE  = $clog2(DATA_WIDTH / 8);
    localparam logic [7:0]  TMO_LIMIT = 8'(TIMEOUT);

    // Reader command / status encodings
    localparam logic [1:0]  CMD_NONE     = 2'd0;
    localparam logic [1:0]  CMD_GET_DATA = 2'd1;
    localparam logic [1:0]  CMD_GET_RESP = 2'd2;
    localparam logic [1:0]  R_IDLE       = 2'd0;
    localparam logic [1:0]  R_BUSY       = 2'd1;
    localparam logic [1:0]  R_SWITCH     = 2'd2;

    // AXI burst type encodings
    localparam logic [1:0]  BURST_FIXED  = 2'd0;
    localparam logic [1:0]  BURST_WRAP   = 2'd2;
    localparam logic [1:0]  BURST_RSVD   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_COLLECT,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DRAIN,
        S_RESP,
        S_BRESP
    } state_t;

    state_t                  state;
    state_t                  state_d;

    logic [3:0]              len_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic [4:0]              beat_cnt;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    err_q;
    logic [7:0]              tmo_q;
    logic [1:0]              resp_q;

    logic                    burst_legal;
    logic                    issue_fire;
    logic                    tmo_hit;
    logic                    last_beat;
    logic                    drain_done;
    logic [4:0]              beats_total;
    logic [ADDR_WIDTH-1:0]   step;
    logic [ADDR_WIDTH-1:0]   wrap_mask;
    logic [ADDR_WIDTH-1:0]   next_addr;

    // A WRAP burst must be 2, 4, 8 or 16 beats long
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    // Legality is judged on the reader's latched fields during SETUP
    always_comb begin
        burst_legal = 1'b1;
        if (ai_burst == BURST_RSVD)
            burst_legal = 1'b0;
        if (ai_size > 3'(MAX_SIZE))
            burst_legal = 1'b0;
        if ((ai_burst == BURST_WRAP) && !wrap_len_ok(ai_len))
            burst_legal = 1'b0;
    end

    // Address of the following beat; the wrap window is (len+1)*step bytes
    always_comb begin
        beats_total = {1'b0, len_q} + 5'd1;
        step        = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;
        wrap_mask   = ({{(ADDR_WIDTH-5){1'b0}}, beats_total} << size_q)
                      - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        case (burst_q)
            BURST_FIXED: next_addr = cur_addr;
            BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + step) & wrap_mask);
            default:     next_addr = cur_addr + step;
        endcase
    end

    assign tmo_hit    = (tmo_q == TMO_LIMIT);
    assign last_beat  = (beat_cnt == {1'b0, len_q});
    assign drain_done = (beat_cnt == beats_total);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // Next-state decode and command outputs; outputs are Moore except the
    // APB handshake pop and the drain pop, which follow the handshake inputs
    always_comb begin
        state_d       = state;
        rd_cmd        = CMD_NONE;
        fifo_read     = 1'b0;
        apb_cmd_valid = 1'b0;
        issue_fire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && (rd_info == R_IDLE))
                    state_d = S_START;
            end
            S_START: begin
                rd_cmd = CMD_GET_DATA;
                if (rd_info == R_BUSY)
                    state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (rd_info == R_SWITCH)
                    state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d = burst_legal ? S_ISSUE : S_DRAIN;
            end
            S_ISSUE: begin
                // Never offer a beat whose data is not yet in the FIFO
                apb_cmd_valid = !fifo_empty;
                issue_fire    = !fifo_empty && apb_cmd_ready;
                fifo_read     = issue_fire;
                if (issue_fire)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (apb_done || tmo_hit)
                    state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = last_beat ? S_RESP : S_ISSUE;
            end
            S_DRAIN: begin
                if (drain_done)
                    state_d = S_RESP;
                else
                    fifo_read = !fifo_empty;
            end
            S_RESP: begin
                rd_cmd = CMD_GET_RESP;
                if (rd_info == R_BUSY)
                    state_d = S_BRESP;
            end
            S_BRESP: begin
                if (rd_info == R_IDLE)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Burst bookkeeping: latched fields, beat counter, address, error, timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            cur_addr <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            resp_q   <= '0;
        end else begin
            case (state)
                S_SETUP: begin
                    len_q    <= ai_len;
                    size_q   <= ai_size;
                    burst_q  <= ai_burst;
                    beat_cnt <= '0;
                    cur_addr <= ai_addr;
                    err_q    <= !burst_legal;
                    tmo_q    <= '0;
                    resp_q   <= '0;
                end
                S_ISSUE: begin
                    if (issue_fire)
                        tmo_q <= '0;
                end
                S_WAIT: begin
                    // A completion landing on the timeout cycle still reports its PSLVERR
                    if (apb_done || tmo_hit) begin
                        err_q <= err_q | (apb_done & apb_slverr) | tmo_hit;
                        tmo_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (last_beat) begin
                        resp_q <= {err_q, 1'b0};
                    end else begin
                        beat_cnt <= beat_cnt + 5'd1;
                        cur_addr <= next_addr;
                    end
                end
                S_DRAIN: begin
                    if (drain_done)
                        resp_q <= {err_q, 1'b0};
                    else if (!fifo_empty)
                        beat_cnt <= beat_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign apb_cmd_addr = cur_addr;
    assign resp         = resp_q;
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_axi2apb_wr_sequencer.sv
// Testbench for axi2apb_wr_sequencer: reactive reader/FIFO/APB models,
// scoreboard of expected APB addresses, pop counts and burst responses.
module tb_axi2apb_wr_sequencer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TMO   = 255;
    localparam int NEVER = 100000;
    localparam int BUDGET = 6000;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [1:0]    rd_cmd;
    logic [1:0]    rd_info;
    logic [AW-1:0] ai_addr;
    logic [3:0]    ai_len;
    logic [2:0]    ai_size;
    logic [1:0]    ai_burst;
    logic          fifo_empty;
    logic          fifo_read;
    logic          apb_cmd_valid;
    logic          apb_cmd_ready;
    logic [AW-1:0] apb_cmd_addr;
    logic          apb_done;
    logic          apb_slverr;
    logic [1:0]    resp;
    logic          busy;

    axi2apb_wr_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rd_cmd(rd_cmd), .rd_info(rd_info),
        .ai_addr(ai_addr), .ai_len(ai_len), .ai_size(ai_size), .ai_burst(ai_burst),
        .fifo_empty(fifo_empty), .fifo_read(fifo_read), .apb_cmd_valid(apb_cmd_valid),
        .apb_cmd_ready(apb_cmd_ready), .apb_cmd_addr(apb_cmd_addr), .apb_done(apb_done),
        .apb_slverr(apb_slverr), .resp(resp), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q[$];
    logic [1:0]  exp_resp_q[$];
    int          exp_pops_q[$];

    int dly[16];
    bit serr[16];

    // driver model state
    int phase, hold, fifo_cnt, wcnt, cur_dly, acc;
    bit pend, cur_serr, vpend;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: expected APB addresses, pops and response from burst rules
    task automatic push_expect(input logic [31:0] a, input int len, input int size, input int burst);
        bit     legal;
        bit     err;
        longint step, w, base, ad, a64;
        legal = (burst != 3) && (size <= 2) &&
                !(burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        exp_pops_q.push_back(len + 1);
        if (!legal) begin
            exp_resp_q.push_back(2'b10);
            return;
        end
        a64  = longint'(a);
        step = longint'(1) << size;
        w    = (len + 1) * step;
        base = a64 - (a64 % w);
        err  = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (burst == 0)      ad = a64;
            else if (burst == 1) ad = (a64 + i * step) % 64'h1_0000_0000;
            else                 ad = base + ((a64 - base) + i * step) % w;
            exp_addr_q.push_back(ad[31:0]);
            if ((serr[i] && dly[i] <= TMO) || dly[i] >= TMO)
                err = 1'b1;
        end
        exp_resp_q.push_back({err, 1'b0});
    endtask

    task automatic fill_easy();
        for (int i = 0; i < 16; i++) begin
            dly[i]  = $urandom_range(0, 3);
            serr[i] = 1'b0;
        end
    endtask

    task automatic fill_random();
        int r;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 99);
            if (r < 88)      dly[i] = $urandom_range(0, 3);
            else if (r < 92) dly[i] = TMO;
            else if (r < 96) dly[i] = TMO + 1;
            else             dly[i] = NEVER;
            serr[i] = ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_rd_cmd"}, rd_cmd, 0);
        check({tag, "_fifo_read"}, fifo_read, 0);
        check({tag, "_apb_valid"}, apb_cmd_valid, 0);
        check({tag, "_apb_addr"}, apb_cmd_addr, 0);
        check({tag, "_resp"}, resp, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        exp_addr_q.delete();
        exp_resp_q.delete();
        exp_pops_q.delete();
        enable     = 1'b0;
        apb_done   = 1'b0;
        apb_slverr = 1'b0;
        rd_info    = 2'd0;
        @(posedge clk);
        #1;
        check_outputs_idle(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one burst through reader, FIFO and APB models; rst_at>=0 aborts
    // with reset while beat rst_at is being offered
    task automatic run_burst(input logic [31:0] a, input int len, input int size,
                             input int burst, input int rst_at);
        push_expect(a, len, size, burst);
        ai_addr  = a;
        ai_len   = 4'(len);
        ai_size  = 3'(size);
        ai_burst = 2'(burst);
        enable   = 1'b1;
        phase = 0; fifo_cnt = 0; pend = 0; acc = 0; vpend = 0; wcnt = 0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            case (phase)
                1: begin rd_info = 2'd1; hold--; if (hold == 0) phase = 2; end
                2: rd_info = 2'd2;
                3: begin rd_info = 2'd1; hold--; if (hold == 0) phase = 4; end
                default: rd_info = 2'd0;
            endcase
            fifo_empty    = (fifo_cnt == 0) || (!vpend && $urandom_range(0, 3) == 0);
            apb_cmd_ready = $urandom_range(0, 1);
            if (pend && wcnt == cur_dly) begin
                apb_done = 1'b1; apb_slverr = cur_serr; pend = 0;
            end else if (!pend && $urandom_range(0, 7) == 0) begin
                apb_done = 1'b1; apb_slverr = 1'b1;
            end else begin
                apb_done = 1'b0; apb_slverr = $urandom_range(0, 1);
            end
            if (pend) wcnt++;
            #1;
            if (rst_at >= 0 && acc == rst_at && apb_cmd_valid) begin
                do_reset("midreset");
                return;
            end
            if (phase == 0 && rd_cmd == 2'd1) begin
                phase = 1; hold = $urandom_range(1, 2); enable = 1'b0;
                fifo_cnt += len + 1;
            end
            if (phase == 2 && rd_cmd == 2'd2) begin
                phase = 3; hold = $urandom_range(1, 3);
            end
            if (phase == 4 && !busy) begin
                apb_done = 1'b0;
                return;
            end
            if (fifo_read && fifo_cnt > 0) fifo_cnt--;
            if (apb_cmd_valid && apb_cmd_ready) begin
                pend = 1; wcnt = 0;
                cur_dly = dly[acc % 16]; cur_serr = serr[acc % 16];
                acc++;
            end
            vpend = apb_cmd_valid && !apb_cmd_ready;
        end
        note_fail("burst_cycle_budget_expired");
        do_reset("recover");
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues
    initial begin
        bit          hold_valid;
        logic [31:0] hold_addr;
        int          pops;
        bit          resp_seen;
        hold_valid = 0; pops = 0; resp_seen = 0; hold_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                hold_valid = 0; pops = 0; resp_seen = 0;
            end else begin
                if (hold_valid) begin
                    check("valid_held", apb_cmd_valid, 1);
                    check("addr_held", apb_cmd_addr, hold_addr);
                end
                if (apb_cmd_valid)
                    check("valid_with_fifo_empty", fifo_empty, 0);
                if (fifo_read)
                    check("pop_with_fifo_empty", fifo_empty, 0);
                if (apb_cmd_valid && apb_cmd_ready) begin
                    if (exp_addr_q.size() == 0)
                        note_fail("unexpected_apb_cmd");
                    else
                        check("apb_addr", apb_cmd_addr, exp_addr_q.pop_front());
                end
                hold_valid = apb_cmd_valid && !apb_cmd_ready;
                hold_addr  = apb_cmd_addr;
                if (fifo_read) pops++;
                if (rd_cmd == 2'd2 && !resp_seen) begin
                    resp_seen = 1;
                    if (exp_resp_q.size() == 0 || exp_pops_q.size() == 0) begin
                        note_fail("unexpected_resp_phase");
                    end else begin
                        check("burst_resp", resp, exp_resp_q.pop_front());
                        check("fifo_pops", pops, exp_pops_q.pop_front());
                    end
                    check("apb_cmds_missing", exp_addr_q.size(), 0);
                    exp_addr_q.delete();
                    pops = 0;
                end
                if (rd_cmd != 2'd2) resp_seen = 0;
            end
        end
    end

    // Stimulus
    initial begin
        int b, l, s;
        rst_n = 1'b0; enable = 1'b0; rd_info = 2'd0; ai_addr = '0; ai_len = '0;
        ai_size = '0; ai_burst = '0; fifo_empty = 1'b1; apb_cmd_ready = 1'b0;
        apb_done = 1'b0; apb_slverr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        fill_easy(); run_burst(32'h1000, 3, 2, 1, -1);
        fill_easy(); run_burst(32'h1008, 3, 2, 2, -1);
        fill_easy(); serr[0] = 1'b1; run_burst(32'h20, 1, 2, 0, -1);
        fill_easy(); dly[0] = NEVER; run_burst(32'h40, 0, 2, 1, -1);
        fill_easy(); dly[1] = TMO; run_burst(32'h80, 1, 2, 1, -1);
        fill_easy(); dly[0] = TMO + 1; run_burst(32'h90, 0, 1, 1, -1);
        fill_easy(); run_burst(32'h100, 2, 2, 3, -1);
        fill_easy(); run_burst(32'h200, 1, 3, 1, -1);
        fill_easy(); run_burst(32'h300, 2, 2, 2, -1);
        fill_easy(); run_burst(32'hFFFF_FFF8, 3, 2, 1, -1);
        fill_easy(); run_burst(32'h3000, 3, 2, 1, 2);
        fill_easy(); run_burst(32'h3000, 3, 2, 1, -1);
        fill_easy(); run_burst(32'h0000_0036, 7, 1, 2, -1);

        for (int t = 0; t < 30; t++) begin
            fill_random();
            b = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            s = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            l = $urandom_range(0, 15);
            if (b == 2 && $urandom_range(0, 4) != 0)
                l = (2 << $urandom_range(0, 3)) - 1;
            run_burst($urandom, l, s, b, -1);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
